// File: rtl/aes_dec_key_gen.sv
// AES-128 decryption round-key generator: expands a cipher key forward to round 10,
// then walks the key schedule backwards, emitting round keys 10 down to 0.
module aes_dec_key_gen (
  input  logic         clk,
  input  logic         nreset,
  input  logic         key_v_i,
  input  logic [127:0] key_i,
  output logic         key_ready_o,
  input  logic         abort_i,
  output logic         rkey_v_o,
  output logic [127:0] rkey_o,
  output logic [3:0]   rkey_round_o,
  input  logic         rkey_ready_i,
  output logic         busy_o
);

  typedef enum logic [1:0] {IDLE, EXPAND, OUT} state_e;

  state_e         state_q, state_d;
  logic [127:0]   key_q, key_d;
  logic [7:0]     rcon_q, rcon_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [3:0]     round_q, round_d;

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ ({8{aa[7]}} & 8'h1b);
    end
    return p;
  endfunction

  // S-box built from the GF(2^8) inverse (x^254) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gfMul(sq, sq);
      inv = gfMul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [31:0] k0, k1, k2, k3;
  logic [31:0] sbIn, rotW, subW, temp;
  logic [31:0] f0, f1, f2, f3;
  logic [31:0] i0, i1, i2, i3;
  logic [7:0]  rconFwd, rconInv;

  assign k0 = key_q[31:0];
  assign k1 = key_q[63:32];
  assign k2 = key_q[95:64];
  assign k3 = key_q[127:96];

  // One set of four S-boxes serves both directions; the inverse round needs the recovered col3.
  assign sbIn = (state_q == OUT) ? (k3 ^ k2) : k3;
  assign rotW = {sbIn[7:0], sbIn[31:8]};
  assign subW = {sbox(rotW[31:24]), sbox(rotW[23:16]), sbox(rotW[15:8]), sbox(rotW[7:0])};
  assign temp = subW ^ {24'h000000, rcon_q};

  assign f0 = k0 ^ temp;
  assign f1 = k1 ^ f0;
  assign f2 = k2 ^ f1;
  assign f3 = k3 ^ f2;

  assign i3 = k3 ^ k2;
  assign i2 = k2 ^ k1;
  assign i1 = k1 ^ k0;
  assign i0 = k0 ^ temp;

  assign rconFwd = {rcon_q[6:0], 1'b0} ^ ({8{rcon_q[7]}} & 8'h1b);
  assign rconInv = (rcon_q[1:0] == 2'b11) ? 8'h80 : {1'b0, rcon_q[7:1]};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rcon_d  = rcon_q;
    cnt_d   = cnt_q;
    round_d = round_q;
    if (abort_i) begin
      state_d = IDLE;
      rcon_d  = 8'h01;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (key_v_i) begin
            key_d   = key_i;
            rcon_d  = 8'h01;
            cnt_d   = 4'd0;
            state_d = EXPAND;
          end
        end
        EXPAND: begin
          key_d = {f3, f2, f1, f0};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd9) begin
            state_d = OUT;
            rcon_d  = 8'h36;
            round_d = 4'd10;
          end else begin
            rcon_d = rconFwd;
          end
        end
        OUT: begin
          if (rkey_ready_i) begin
            if (round_q == 4'd0) begin
              state_d = IDLE;
            end else begin
              key_d   = {i3, i2, i1, i0};
              rcon_d  = rconInv;
              round_d = round_q - 4'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      key_q   <= 128'h0;
      rcon_q  <= 8'h01;
      cnt_q   <= 4'd0;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rcon_q  <= rcon_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
    end
  end

  assign key_ready_o  = (state_q == IDLE);
  assign rkey_v_o     = (state_q == OUT);
  assign busy_o       = (state_q != IDLE);
  assign rkey_o       = key_q;
  assign rkey_round_o = round_q;

endmodule
